// File: rtl/arrow_scheduler_if.sv
// Arrow scheduler bus: metronome/random-generator/button inputs and the
// renderer/score-display outputs, grouped for the scheduler and its environment.
interface arrow_scheduler_if #(
  parameter int ARROW_BITS = 2,
  parameter int CNT_BITS   = 8
);
  logic                  beat;
  logic                  run;
  logic [ARROW_BITS-1:0] rand_arrow;
  logic                  rand_next;
  logic [3:0]            btn;
  logic                  spawn_valid;
  logic [ARROW_BITS-1:0] spawn_arrow;
  logic                  target_valid;
  logic [ARROW_BITS-1:0] target_arrow;
  logic [3:0]            occupancy;
  logic                  hit;
  logic                  miss;
  logic [CNT_BITS-1:0]   hits;
  logic [CNT_BITS-1:0]   misses;
  logic [CNT_BITS-1:0]   combo;
  logic                  busy;

  modport master (
    input  beat, run, rand_arrow, btn,
    output rand_next, spawn_valid, spawn_arrow, target_valid, target_arrow,
           occupancy, hit, miss, hits, misses, combo, busy
  );

  modport slave (
    output beat, run, rand_arrow, btn,
    input  rand_next, spawn_valid, spawn_arrow, target_valid, target_arrow,
           occupancy, hit, miss, hits, misses, combo, busy
  );
endinterface

// File: rtl/arrow_scheduler.sv
// DDR arrow scheduler: spawns one arrow per beat, ages in-flight arrows and
// judges presses at the target row, keeping saturating hit/miss/combo counts.
module arrow_scheduler #(
  parameter int ARROW_BITS   = 2,
  parameter int TRAVEL_BEATS = 4,
  parameter int QUEUE_DEPTH  = 8,
  parameter int CNT_BITS     = 8
) (
  input  logic              clk,
  input  logic              rst,
  arrow_scheduler_if.master bus
);

  localparam int IW = $clog2(QUEUE_DEPTH);
  localparam int PW = IW + 1;
  localparam int AW = (TRAVEL_BEATS < 1) ? 1 : $clog2(TRAVEL_BEATS + 1);
  localparam logic [PW-1:0] DEPTH_P  = PW'(QUEUE_DEPTH);
  localparam logic [AW-1:0] TRAVEL_P = AW'(TRAVEL_BEATS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [ARROW_BITS-1:0] arrow_q [QUEUE_DEPTH];
  logic [AW-1:0]         age_q   [QUEUE_DEPTH];

  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic                  hit_q, hit_d;
  logic                  miss_q, miss_d;
  logic                  spawn_q, spawn_d;
  logic [ARROW_BITS-1:0] spawn_arrow_q, spawn_arrow_d;
  logic [CNT_BITS-1:0]   hits_q, hits_d;
  logic [CNT_BITS-1:0]   misses_q, misses_d;
  logic [CNT_BITS-1:0]   combo_q, combo_d;

  logic [IW-1:0]         head_idx, tail_idx;
  logic [PW-1:0]         occ, occ_post;
  logic                  tgt_valid;
  logic [ARROW_BITS-1:0] tgt_arrow;
  logic [3:0]            tgt_onehot;
  logic                  pop_press, expire, aging;

  assign head_idx   = head_q[IW-1:0];
  assign tail_idx   = tail_q[IW-1:0];
  assign occ        = tail_q - head_q;
  assign tgt_arrow  = arrow_q[head_idx];
  assign tgt_valid  = (occ != '0) && (age_q[head_idx] == TRAVEL_P);
  assign tgt_onehot = 4'b0001 << tgt_arrow;

  always_comb begin
    state_d       = state_q;
    head_d        = head_q;
    tail_d        = tail_q;
    hit_d         = 1'b0;
    miss_d        = 1'b0;
    spawn_d       = 1'b0;
    spawn_arrow_d = '0;
    hits_d        = hits_q;
    misses_d      = misses_q;
    combo_d       = combo_q;
    occ_post      = occ;
    pop_press     = 1'b0;
    expire        = 1'b0;
    aging         = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.run) begin
          state_d  = PLAY;
          hits_d   = '0;
          misses_d = '0;
          combo_d  = '0;
        end
      end
      PLAY: begin
        if (!bus.run) state_d = DRAIN;
      end
      DRAIN: begin
        if (bus.run)         state_d = PLAY;
        else if (occ == '0)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      pop_press = (bus.btn != 4'b0000) && tgt_valid;
      if (pop_press) begin
        if (bus.btn == tgt_onehot) hit_d  = 1'b1;
        else                       miss_d = 1'b1;
      end
      // Ages are distinct, so a press pop leaves no entry at target to expire.
      expire   = bus.beat && tgt_valid && !pop_press;
      if (expire) miss_d = 1'b1;
      aging    = bus.beat;
      head_d   = head_q + PW'(pop_press || expire);
      occ_post = occ - PW'(pop_press || expire);
      if (bus.beat && (state_q == PLAY) && (occ_post < DEPTH_P)) begin
        spawn_d       = 1'b1;
        spawn_arrow_d = bus.rand_arrow;
        tail_d        = tail_q + PW'(1);
      end
    end

    if (hit_d) begin
      if (hits_q  != '1) hits_d  = hits_q  + CNT_BITS'(1);
      if (combo_q != '1) combo_d = combo_q + CNT_BITS'(1);
    end
    if (miss_d) begin
      if (misses_q != '1) misses_d = misses_q + CNT_BITS'(1);
      combo_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      head_q        <= '0;
      tail_q        <= '0;
      hit_q         <= 1'b0;
      miss_q        <= 1'b0;
      spawn_q       <= 1'b0;
      spawn_arrow_q <= '0;
      hits_q        <= '0;
      misses_q      <= '0;
      combo_q       <= '0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      hit_q         <= hit_d;
      miss_q        <= miss_d;
      spawn_q       <= spawn_d;
      spawn_arrow_q <= spawn_arrow_d;
      hits_q        <= hits_d;
      misses_q      <= misses_d;
      combo_q       <= combo_d;
    end
  end

  // Slot storage needs no reset: validity comes from the pointers. Aging every
  // slot (live or not) is harmless; the spawn write overrides its own slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (aging) begin
        for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
          age_q[i] <= age_q[i] + AW'(1);
        end
      end
      if (spawn_d) begin
        arrow_q[tail_idx] <= bus.rand_arrow;
        age_q[tail_idx]   <= '0;
      end
    end
  end

  assign bus.rand_next    = spawn_q;
  assign bus.spawn_valid  = spawn_q;
  assign bus.spawn_arrow  = spawn_arrow_q;
  assign bus.target_valid = tgt_valid;
  assign bus.target_arrow = tgt_arrow;
  assign bus.occupancy    = 4'(occ);
  assign bus.hit          = hit_q;
  assign bus.miss         = miss_q;
  assign bus.hits         = hits_q;
  assign bus.misses       = misses_q;
  assign bus.combo        = combo_q;
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_arrow_scheduler.sv
// Self-checking bench for arrow_scheduler against a queue-based reference model.
module tb_arrow_scheduler;

  localparam int AB   = 2;
  localparam int TRV  = 4;
  localparam int QD   = 8;
  localparam int CB   = 8;
  localparam int CMAX = (1 << CB) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arrow_scheduler_if #(.ARROW_BITS(AB), .CNT_BITS(CB)) bus ();

  arrow_scheduler #(
    .ARROW_BITS  (AB),
    .TRAVEL_BEATS(TRV),
    .QUEUE_DEPTH (QD),
    .CNT_BITS    (CB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: in-flight arrows as parallel queues, head at index 0.
  int q_arrow[$];
  int q_age[$];
  int m_mode;   // 0 idle, 1 playing, 2 draining
  int m_hits, m_misses, m_combo;
  int e_hit, e_miss, e_spawn, e_sarrow;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic bit m_tv();
    return (q_age.size() != 0) && (q_age[0] == TRV);
  endfunction

  task automatic model_reset();
    q_arrow.delete();
    q_age.delete();
    m_mode = 0;
    m_hits = 0; m_misses = 0; m_combo = 0;
    e_hit = 0; e_miss = 0; e_spawn = 0; e_sarrow = 0;
  endtask

  task automatic model_step(input bit b, input bit r, input logic [3:0] bt, input int ra);
    int  occ0 = q_arrow.size();
    bit  tv   = m_tv();
    logic [3:0] want;
    e_hit = 0; e_miss = 0; e_spawn = 0;
    if (m_mode == 0) begin
      if (r) begin
        m_mode = 1; m_hits = 0; m_misses = 0; m_combo = 0;
      end
    end else begin
      if (bt != 4'b0000 && tv) begin
        want = 4'b0001 << q_arrow[0];
        if (bt == want) e_hit = 1; else e_miss = 1;
        void'(q_arrow.pop_front()); void'(q_age.pop_front());
      end
      if (b && m_tv()) begin
        e_miss = 1;
        void'(q_arrow.pop_front()); void'(q_age.pop_front());
      end
      if (b) foreach (q_age[i]) q_age[i] = q_age[i] + 1;
      if (b && m_mode == 1 && q_arrow.size() < QD) begin
        q_arrow.push_back(ra); q_age.push_back(0);
        e_spawn = 1; e_sarrow = ra;
      end
      if (e_hit) begin
        if (m_hits < CMAX) m_hits++;
        if (m_combo < CMAX) m_combo++;
      end
      if (e_miss) begin
        if (m_misses < CMAX) m_misses++;
        m_combo = 0;
      end
      if (m_mode == 1) begin
        if (!r) m_mode = 2;
      end else begin
        if (r) m_mode = 1;
        else if (occ0 == 0) m_mode = 0;
      end
    end
  endtask

  task automatic compare_all(input string ph);
    check({ph, "_hit"},    bus.hit, e_hit);
    check({ph, "_miss"},   bus.miss, e_miss);
    check({ph, "_spawn"},  bus.spawn_valid, e_spawn);
    check({ph, "_rnext"},  bus.rand_next, e_spawn);
    if (e_spawn != 0) check({ph, "_sarrow"}, bus.spawn_arrow, e_sarrow);
    check({ph, "_hits"},   bus.hits, m_hits);
    check({ph, "_misses"}, bus.misses, m_misses);
    check({ph, "_combo"},  bus.combo, m_combo);
    check({ph, "_occ"},    bus.occupancy, q_arrow.size());
    check({ph, "_tv"},     bus.target_valid, m_tv());
    if (m_tv()) check({ph, "_tarrow"}, bus.target_arrow, q_arrow[0]);
    check({ph, "_busy"},   bus.busy, m_mode != 0);
  endtask

  task automatic step(input string ph, input bit b, input bit r, input logic [3:0] bt, input int ra);
    bus.beat = b; bus.run = r; bus.btn = bt; bus.rand_arrow = AB'(ra);
    model_step(b, r, bt, ra);
    @(posedge clk); #1;
    bus.beat = 1'b0; bus.btn = 4'b0000;
    compare_all(ph);
  endtask

  task automatic do_reset(input string ph);
    rst = 1'b1;
    bus.beat = 1'b0; bus.btn = 4'b0000;
    @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
    compare_all(ph);
  endtask

  function automatic logic [3:0] correct_btn();
    logic [3:0] v = 4'b0000;
    if (m_tv()) v = 4'b0001 << q_arrow[0];
    return v;
  endfunction

  function automatic logic [3:0] wrong_btn();
    logic [3:0] v = 4'b0001;
    if (q_arrow.size() != 0) v = 4'b0001 << ((q_arrow[0] + 1) % 4);
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int m0, occ_before, k;
    logic [3:0] bt;
    bus.run = 1'b0; bus.beat = 1'b0; bus.btn = 4'b0000; bus.rand_arrow = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    do_reset("rst");

    // Five beats of code 2: oldest arrow lands on target.
    step("start", 0, 1, 4'b0000, 2);
    for (int i = 0; i < 5; i++) begin
      step("fill", 1, 1, 4'b0000, 2);
      step("fill", 0, 1, 4'b0000, 2);
    end
    check("tp1_occ", bus.occupancy, 5);
    check("tp1_tv", bus.target_valid, 1);
    check("tp1_tarrow", bus.target_arrow, 2);

    step("tp2", 0, 1, 4'b0100, 1);
    check("tp2_hitpulse", bus.hit, 1);
    check("tp2_hits", bus.hits, 1);
    check("tp2_combo", bus.combo, 1);
    check("tp2_occ", bus.occupancy, 4);
    check("tp2_tv", bus.target_valid, 0);

    // Wrong press on the next target, then a press with nothing on target.
    step("tp3", 1, 1, 4'b0000, 1);
    step("tp3", 0, 1, wrong_btn(), 1);
    check("tp3_misses", bus.misses, 1);
    check("tp3_combo", bus.combo, 0);
    step("tp3_idle", 0, 1, 4'b0010, 3);

    // Unjudged arrow expires on the beat; then correct press coincides with beat.
    step("tp4", 1, 1, 4'b0000, 0);
    occ_before = q_arrow.size();
    step("tp4", 1, 1, 4'b0000, 3);
    check("tp4_expire_miss", bus.miss, 1);
    check("tp4_occ_same", bus.occupancy, occ_before);
    step("tp4", 0, 1, 4'b0000, 3);
    step("tp4", 1, 1, correct_btn(), 2);
    check("tp4_beat_hit", bus.hit, 1);
    check("tp4_beat_nomiss", bus.miss, 0);

    // Randomized play with occasional run toggling.
    for (int i = 0; i < 600; i++) begin
      k = $urandom_range(0, 5);
      case (k)
        0, 1: bt = 4'b0000;
        2, 3: bt = m_tv() ? correct_btn() : 4'b0001 << $urandom_range(0, 3);
        4:    bt = wrong_btn();
        default: bt = 4'($urandom_range(0, 15));
      endcase
      step("rnd", $urandom_range(0, 2) == 0, $urandom_range(0, 39) != 0, bt,
           $urandom_range(0, 3));
    end

    // Drain: reach steady occupancy 5, drop run, let every arrow expire.
    do_reset("rst2");
    step("d_start", 0, 1, 4'b0000, 0);
    for (int i = 0; i < 8; i++) begin
      step("d_fill", 1, 1, 4'b0000, $urandom_range(0, 3));
      step("d_fill", 0, 1, 4'b0000, 0);
    end
    check("drain_occ5", bus.occupancy, 5);
    m0 = m_misses;
    step("drain", 0, 0, 4'b0000, 0);
    for (int i = 0; i < 40 && bus.busy; i++) begin
      step("drain", (i % 2) == 0, 0, 4'b0000, $urandom_range(0, 3));
    end
    check("drain_idle", bus.busy, 0);
    check("drain_misses", bus.misses, m0 + 5);

    // Long run of correct hits into saturation.
    step("sat_start", 0, 1, 4'b0000, 0);
    for (int i = 0; i < 270; i++) begin
      step("sat", 1, 1, 4'b0000, $urandom_range(0, 3));
      step("sat", 0, 1, correct_btn(), 0);
    end
    check("sat_hits", bus.hits, CMAX);
    check("sat_combo", bus.combo, CMAX);

    // Mid-game reset with an arrow on target and a beat pending.
    step("pre_rst", 1, 1, 4'b0000, 1);
    rst = 1'b1;
    bus.beat = 1'b1;
    @(posedge clk); #1;
    bus.beat = 1'b0;
    rst = 1'b0;
    model_reset();
    compare_all("midrst");
    check("midrst_nomiss", bus.miss, 0);
    step("post_rst", 1, 0, 4'b0000, 2);
    check("post_rst_idle_beat", bus.occupancy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
